// File: rtl/vending_fsm_param.sv
// Parametrised credit-accumulating vending controller: collects 5/10/25 coins,
// vends at PRICE, pays change or refunds one greedy coin per cycle, counts sales.
module vending_fsm_param #(
  parameter int PRICE    = 25,
  parameter int AMOUNT_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c5,
  input  logic                c10,
  input  logic                c25,
  input  logic                cancel,
  input  logic                item_taken,
  output logic                dispense,
  output logic                r5,
  output logic                r10,
  output logic                r25,
  output logic                coin_reject,
  output logic [AMOUNT_W-1:0] amount,
  output logic [CNT_W-1:0]    sales
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE, REFUND} state_t;

  localparam logic [AMOUNT_W-1:0] PRICE_A = AMOUNT_W'(PRICE);
  localparam logic [AMOUNT_W-1:0] V5      = AMOUNT_W'(5);
  localparam logic [AMOUNT_W-1:0] V10     = AMOUNT_W'(10);
  localparam logic [AMOUNT_W-1:0] V25     = AMOUNT_W'(25);

  state_t              state, state_n;
  logic [AMOUNT_W-1:0] amount_n, coin_val, pay_val, credit_sum;
  logic [CNT_W-1:0]    sales_n;
  logic                coin_any, coin_one_hot, paying_n;

  // Three-way XOR is also true with all three high, so that case is excluded.
  assign coin_any     = c5 | c10 | c25;
  assign coin_one_hot = (c5 ^ c10 ^ c25) & ~(c5 & c10 & c25);
  assign coin_reject  = coin_any & (~coin_one_hot | (state != COLLECT) | cancel);

  always_comb begin
    coin_val   = c25 ? V25 : (c10 ? V10 : V5);
    pay_val    = (amount >= V25) ? V25 : ((amount >= V10) ? V10 : V5);
    credit_sum = amount + coin_val;
    state_n    = state;
    amount_n   = amount;
    sales_n    = sales;
    case (state)
      COLLECT: begin
        if (cancel) begin
          if (amount != '0) state_n = REFUND;
        end else if (coin_one_hot) begin
          amount_n = credit_sum;
          if (credit_sum >= PRICE_A) state_n = VEND;
        end
      end
      VEND: begin
        if (item_taken) begin
          sales_n  = sales + CNT_W'(1);
          amount_n = amount - PRICE_A;
          state_n  = (amount == PRICE_A) ? COLLECT : CHANGE;
        end
      end
      CHANGE, REFUND: begin
        amount_n = amount - pay_val;
        if (amount == pay_val) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  assign paying_n = (state_n == CHANGE) || (state_n == REFUND);

  // Return-coin outputs are registered from the next payout amount, so each
  // pulse lines up with the amount it is paying out of.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      amount   <= '0;
      sales    <= '0;
      dispense <= 1'b0;
      r5       <= 1'b0;
      r10      <= 1'b0;
      r25      <= 1'b0;
    end else begin
      state    <= state_n;
      amount   <= amount_n;
      sales    <= sales_n;
      dispense <= (state_n == VEND);
      r25      <= paying_n && (amount_n >= V25);
      r10      <= paying_n && (amount_n < V25) && (amount_n >= V10);
      r5       <= paying_n && (amount_n < V10);
    end
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: two instances (PRICE 25 and PRICE 50 / CNT_W 2)
// checked against a queue-of-coins reference model.
module tb_vending_fsm_param;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] C5   = 5'b00001;
  localparam logic [4:0] C10  = 5'b00010;
  localparam logic [4:0] C25  = 5'b00100;
  localparam logic [4:0] CAN  = 5'b01000;
  localparam logic [4:0] TAKE = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] in0, in1;

  logic       dispense0, r5_0, r10_0, r25_0, reject0;
  logic [7:0] amount0;
  logic [15:0] sales0;
  logic       dispense1, r5_1, r10_1, r25_1, reject1;
  logic [7:0] amount1;
  logic [1:0] sales1;

  int n_vec = 0;
  int n_bad = 0;

  int credit   [2];
  bit vending  [2];
  int pay      [2][8];
  int pay_len  [2];
  int pay_idx  [2];
  int sales_m  [2];
  int price    [2] = '{25, 50};
  int cnt_mod  [2] = '{65536, 4};

  always #5 clk = ~clk;

  vending_fsm_param #(.PRICE(25), .AMOUNT_W(8), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset),
    .c5(in0[0]), .c10(in0[1]), .c25(in0[2]), .cancel(in0[3]), .item_taken(in0[4]),
    .dispense(dispense0), .r5(r5_0), .r10(r10_0), .r25(r25_0),
    .coin_reject(reject0), .amount(amount0), .sales(sales0)
  );

  vending_fsm_param #(.PRICE(50), .AMOUNT_W(8), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset),
    .c5(in1[0]), .c10(in1[1]), .c25(in1[2]), .cancel(in1[3]), .item_taken(in1[4]),
    .dispense(dispense1), .r5(r5_1), .r10(r10_1), .r25(r25_1),
    .coin_reject(reject1), .amount(amount1), .sales(sales1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Payout is precomputed as an explicit list of coins, largest first.
  task automatic build_payout(input int d, input int total);
    int rem;
    rem = total;
    pay_len[d] = 0;
    pay_idx[d] = 0;
    while (rem > 0) begin
      if (rem >= 25)      pay[d][pay_len[d]] = 25;
      else if (rem >= 10) pay[d][pay_len[d]] = 10;
      else                pay[d][pay_len[d]] = 5;
      rem -= pay[d][pay_len[d]];
      pay_len[d]++;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      credit[d]  = 0;
      vending[d] = 1'b0;
      pay_len[d] = 0;
      pay_idx[d] = 0;
      sales_m[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [4:0] s, output bit exp_rej);
    int  n, val;
    bit  payout, collecting;
    n          = int'(s[0]) + int'(s[1]) + int'(s[2]);
    val        = s[0] ? 5 : (s[1] ? 10 : 25);
    payout     = pay_idx[d] < pay_len[d];
    collecting = !vending[d] && !payout;
    exp_rej    = (n > 0) && (n != 1 || !collecting || s[3]);
    if (collecting) begin
      if (s[3]) begin
        if (credit[d] > 0) begin
          build_payout(d, credit[d]);
          credit[d] = 0;
        end
      end else if (n == 1) begin
        credit[d] += val;
        if (credit[d] >= price[d]) vending[d] = 1'b1;
      end
    end else if (vending[d]) begin
      if (s[4]) begin
        sales_m[d] = (sales_m[d] + 1) % cnt_mod[d];
        build_payout(d, credit[d] - price[d]);
        credit[d]  = 0;
        vending[d] = 1'b0;
      end
    end else begin
      pay_idx[d]++;
    end
  endtask

  task automatic checkState(input int d);
    int remaining, cur;
    remaining = 0;
    for (int i = pay_idx[d]; i < pay_len[d]; i++) remaining += pay[d][i];
    cur = (pay_idx[d] < pay_len[d]) ? pay[d][pay_idx[d]] : 0;
    if (d == 0) begin
      checkOutput("amount0",   32'(amount0),   32'(credit[0] + remaining));
      checkOutput("dispense0", 32'(dispense0), 32'(vending[0]));
      checkOutput("rcoins0",   32'({r25_0, r10_0, r5_0}),
                  32'({cur == 25, cur == 10, cur == 5}));
      checkOutput("sales0",    32'(sales0),    32'(sales_m[0]));
    end else begin
      checkOutput("amount1",   32'(amount1),   32'(credit[1] + remaining));
      checkOutput("dispense1", 32'(dispense1), 32'(vending[1]));
      checkOutput("rcoins1",   32'({r25_1, r10_1, r5_1}),
                  32'({cur == 25, cur == 10, cur == 5}));
      checkOutput("sales1",    32'(sales1),    32'(sales_m[1]));
    end
  endtask

  task automatic applyStimulus(input logic [4:0] s0, input logic [4:0] s1);
    bit e0, e1;
    @(negedge clk);
    in0 = s0;
    in1 = s1;
    #1;
    model_step(0, s0, e0);
    model_step(1, s1, e1);
    checkOutput("coin_reject0", 32'(reject0), 32'(e0));
    checkOutput("coin_reject1", 32'(reject1), 32'(e1));
    @(posedge clk);
    #1;
    checkState(0);
    checkState(1);
  endtask

  // Reset is raised between edges so its asynchronous effect is observable.
  task automatic pulseReset();
    @(negedge clk);
    in0   = IDLE;
    in1   = IDLE;
    reset = 1'b1;
    #1;
    model_reset();
    checkState(0);
    checkState(1);
    checkOutput("reset_reject0", 32'(reject0), 32'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [4:0] rand_in();
    case ($urandom_range(0, 9))
      0, 1:    return C5;
      2, 3:    return C10;
      4:       return C25;
      5:       return CAN;
      6, 7:    return TAKE;
      8:       return 5'($urandom_range(0, 31));
      default: return IDLE;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in0   = IDLE;
    in1   = IDLE;
    model_reset();
    #1;
    checkState(0);
    checkState(1);
    checkOutput("init_reject0", 32'(reject0), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] exact-price sale");
    applyStimulus(C5, IDLE);
    applyStimulus(C10, IDLE);
    applyStimulus(C10, IDLE);
    applyStimulus(TAKE, IDLE);

    $display("[TB] sale with change, coin offered during vend");
    applyStimulus(C10, IDLE);
    applyStimulus(C10, IDLE);
    applyStimulus(C25, IDLE);
    applyStimulus(C25, IDLE);
    applyStimulus(CAN, IDLE);
    applyStimulus(TAKE, IDLE);
    applyStimulus(IDLE, IDLE);
    applyStimulus(IDLE, IDLE);

    $display("[TB] cancel refund, coin accepted right after payout");
    applyStimulus(C5, IDLE);
    applyStimulus(C10, IDLE);
    applyStimulus(CAN, IDLE);
    applyStimulus(C5, IDLE);
    applyStimulus(IDLE, IDLE);
    applyStimulus(C5, IDLE);
    applyStimulus(CAN, IDLE);
    applyStimulus(IDLE, IDLE);

    $display("[TB] illegal coin combinations");
    applyStimulus(C5 | C10, IDLE);
    applyStimulus(CAN, IDLE);
    applyStimulus(C5, IDLE);
    applyStimulus(C10 | CAN, IDLE);
    applyStimulus(IDLE, IDLE);
    applyStimulus(C5 | C10 | C25, TAKE);

    $display("[TB] reset during change");
    applyStimulus(C5, IDLE);
    applyStimulus(C10, IDLE);
    applyStimulus(C25, IDLE);
    applyStimulus(TAKE, IDLE);
    pulseReset();
    applyStimulus(IDLE, IDLE);

    $display("[TB] price 50 with 2-bit sales counter wrap");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(IDLE, C25);
      applyStimulus(IDLE, C25);
      applyStimulus(IDLE, TAKE);
    end
    applyStimulus(IDLE, C10);
    applyStimulus(IDLE, C25);
    applyStimulus(IDLE, C25);
    applyStimulus(IDLE, TAKE);
    applyStimulus(IDLE, IDLE);
    applyStimulus(IDLE, IDLE);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(rand_in(), rand_in());
      if (i == 200) pulseReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
